// File: rtl/exec_mdu_sequencer.sv
// Multi-cycle RV64 M-extension multiply/divide sequencer for the execute stage.
// Captures operands when an M-type instruction starts, runs DATA_WIDTH iterations of
// shift-add multiply or restoring divide on magnitudes, then applies the recorded sign.
// Divide-by-zero and signed overflow resolve in one cycle without iterating.
//
// Ports:
//   i_clk, i_arst          clock (rising edge), asynchronous active-high reset
//   i_start                valid M-type instruction in execute this cycle
//   i_func3, i_word        operation select and RV64 W-variant flag
//   i_src_1, i_src_2       forwarded rs1 / rs2 values
//   i_flush                kill the execute-stage instruction (overrides i_start)
//   o_stall                hold fetch/decode/execute pipeline registers
//   o_busy                 sequencer not idle
//   o_done                 one-cycle pulse, o_result valid
//   o_result               final result, held until the next completion
//
// DATA_WIDTH must be greater than 32 (W variants use the low 32 bits).

module exec_mdu_sequencer #(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic                  i_start,
  input  logic [2:0]            i_func3,
  input  logic                  i_word,
  input  logic [DATA_WIDTH-1:0] i_src_1,
  input  logic [DATA_WIDTH-1:0] i_src_2,
  input  logic                  i_flush,
  output logic                  o_stall,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_result
);

  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned CntW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2*W-1:0]  acc_q, acc_d;     // mul: {partial, multiplier}; div: {remainder, dividend/quotient}
  logic [W-1:0]    mcand_q, mcand_d; // multiplicand or divisor magnitude
  logic [2:0]      op_q, op_d;
  logic            word_q, word_d;
  logic            neg_q, neg_d;     // negate the selected result at the end
  logic [W-1:0]    result_q, result_d;

  function automatic logic [W-1:0] word_fix(input logic word, input logic [W-1:0] v);
    return word ? {{(W-32){v[31]}}, v[31:0]} : v;
  endfunction

  // ---------------------------------------------------------------------------
  // Operand preparation and special-case detection at capture
  // ---------------------------------------------------------------------------
  logic         capture, is_div, sgn1, sgn2, neg1, neg2, div_zero, div_ovf, special, cap_neg;
  logic [W-1:0] op1_ext, op2_ext, mag1, mag2, min_int, spec_res;

  always_comb begin
    is_div   = i_func3[2];
    // Unsigned rs1 for mulhu/divu/remu; rs2 additionally unsigned for mulhsu.
    sgn1     = ~(i_func3[0] & (i_func3[1] | i_func3[2]));
    sgn2     = sgn1 & (i_func3 != 3'd2);
    op1_ext  = i_word ? {{(W-32){sgn1 & i_src_1[31]}}, i_src_1[31:0]} : i_src_1;
    op2_ext  = i_word ? {{(W-32){sgn2 & i_src_2[31]}}, i_src_2[31:0]} : i_src_2;
    neg1     = sgn1 & op1_ext[W-1];
    neg2     = sgn2 & op2_ext[W-1];
    mag1     = neg1 ? -op1_ext : op1_ext;
    mag2     = neg2 ? -op2_ext : op2_ext;
    // Word min-int is compared after sign extension.
    min_int  = i_word ? {{(W-31){1'b1}}, {31{1'b0}}} : {1'b1, {(W-1){1'b0}}};
    div_zero = is_div & (op2_ext == '0);
    div_ovf  = is_div & sgn2 & (op1_ext == min_int) & (op2_ext == '1);
    special  = div_zero | div_ovf;
    if (i_func3[1]) spec_res = div_zero ? op1_ext : '0;  // rem/remu
    else            spec_res = div_zero ? '1 : op1_ext;  // div/divu
    // Remainder follows the dividend sign; everything else takes the product of signs.
    cap_neg  = (is_div & i_func3[1]) ? neg1 : (neg1 ^ neg2);
  end

  assign capture = (state_q == StIdle) & i_start & ~i_flush;

  // ---------------------------------------------------------------------------
  // One iteration of multiply or divide, and the result it would finish with
  // ---------------------------------------------------------------------------
  logic [W:0]     mul_sum, div_trial;
  logic [W-1:0]   div_diff, mul_res, div_res, div_res_s, calc_res;
  logic           div_ge;
  logic [2*W-1:0] iter_next, prod_s;

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    // Shifted remainder needs W+1 bits: its top bit comes from the old remainder MSB.
    div_trial = acc_q[2*W-1:W-1];
    div_ge    = div_trial >= {1'b0, mcand_q};
    div_diff  = div_trial[W-1:0] - mcand_q;
    if (op_q[2]) begin
      iter_next = {(div_ge ? div_diff : div_trial[W-1:0]), acc_q[W-2:0], div_ge};
    end else begin
      iter_next = {mul_sum, acc_q[W-1:1]};
    end
    prod_s    = neg_q ? -iter_next : iter_next;
    mul_res   = (op_q[1:0] == 2'd0) ? prod_s[W-1:0] : prod_s[2*W-1:W];
    div_res   = op_q[1] ? iter_next[2*W-1:W] : iter_next[W-1:0];
    div_res_s = neg_q ? -div_res : div_res;
    calc_res  = word_fix(word_q, op_q[2] ? div_res_s : mul_res);
  end

  // ---------------------------------------------------------------------------
  // FSM: state register, next state, outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (i_start && !i_flush) state_d = special ? StDone : StCalc;
      StCalc: begin
        if (i_flush)                 state_d = StIdle;
        else if (cnt_q == LastCnt)   state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    o_busy   = (state_q != StIdle);
    o_done   = (state_q == StDone);
    o_stall  = capture | (state_q == StCalc);
    o_result = result_q;
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_comb begin
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    op_d     = op_q;
    word_d   = word_q;
    neg_d    = neg_q;
    result_d = result_q;
    case (state_q)
      StIdle: begin
        if (capture) begin
          op_d    = i_func3;
          word_d  = i_word;
          neg_d   = cap_neg;
          cnt_d   = '0;
          acc_d   = {{W{1'b0}}, (is_div ? mag1 : mag2)};
          mcand_d = is_div ? mag2 : mag1;
          if (special) result_d = word_fix(i_word, spec_res);
        end
      end
      StCalc: begin
        if (!i_flush) begin
          acc_d = iter_next;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LastCnt) result_d = calc_res;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst) begin
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      op_q     <= '0;
      word_q   <= 1'b0;
      neg_q    <= 1'b0;
      result_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      op_q     <= op_d;
      word_q   <= word_d;
      neg_q    <= neg_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_exec_mdu_sequencer.sv
// Self-checking bench for exec_mdu_sequencer (DATA_WIDTH = 64).
// A reference model computes results with native wide arithmetic and tracks expected
// stall/busy/done/result per cycle; directed vectors also check literal results,
// latency and stall length.

module tb_exec_mdu_sequencer;

  logic        clk = 1'b0;
  logic        arst;
  logic        start;
  logic [2:0]  func3;
  logic        word;
  logic [63:0] src_1, src_2;
  logic        flush;
  logic        stall, busy, done;
  logic [63:0] result;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_en = 1'b0;

  exec_mdu_sequencer #(.DATA_WIDTH(64)) dut (
    .i_clk    (clk),
    .i_arst   (arst),
    .i_start  (start),
    .i_func3  (func3),
    .i_word   (word),
    .i_src_1  (src_1),
    .i_src_2  (src_2),
    .i_flush  (flush),
    .o_stall  (stall),
    .o_busy   (busy),
    .o_done   (done),
    .o_result (result)
  );

  always #5 clk = ~clk;

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic chkint(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  function automatic logic is_signed1(input logic [2:0] f);
    return !(f == 3'd3 || f == 3'd5 || f == 3'd7);
  endfunction

  function automatic logic is_signed2(input logic [2:0] f);
    return is_signed1(f) && (f != 3'd2);
  endfunction

  function automatic logic [63:0] ext(input logic w, input logic s, input logic [63:0] v);
    if (!w) return v;
    return s ? {{32{v[31]}}, v[31:0]} : {32'h0, v[31:0]};
  endfunction

  function automatic logic ref_special(input logic [2:0] f, input logic w,
                                       input logic [63:0] a, input logic [63:0] b);
    logic [63:0] ea, eb, minv;
    ea   = ext(w, is_signed1(f), a);
    eb   = ext(w, is_signed2(f), b);
    minv = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    return f[2] && (eb == 64'h0 || (is_signed2(f) && ea == minv && eb == '1));
  endfunction

  function automatic logic [63:0] ref_result(input logic [2:0] f, input logic w,
                                             input logic [63:0] a, input logic [63:0] b);
    logic [63:0]        ea, eb, q, rm, r, minv;
    logic [127:0]       wa, wb, p;
    logic signed [63:0] sa, sb, sq, sr;
    ea   = ext(w, is_signed1(f), a);
    eb   = ext(w, is_signed2(f), b);
    minv = w ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000;
    if (!f[2]) begin
      wa = is_signed1(f) ? {{64{ea[63]}}, ea} : {64'h0, ea};
      wb = is_signed2(f) ? {{64{eb[63]}}, eb} : {64'h0, eb};
      p  = wa * wb;
      r  = (f == 3'd0) ? p[63:0] : p[127:64];
    end else begin
      if (eb == 64'h0) begin
        q = '1; rm = ea;
      end else if (is_signed2(f) && ea == minv && eb == '1) begin
        q = ea; rm = 64'h0;
      end else if (is_signed2(f)) begin
        sa = ea; sb = eb; sq = sa / sb; sr = sa % sb;
        q = sq; rm = sr;
      end else begin
        q = ea / eb; rm = ea % eb;
      end
      r = f[1] ? rm : q;
    end
    if (w) r = {{32{r[31]}}, r[31:0]};
    return r;
  endfunction

  int          m_left = 0;   // CALC cycles still to run
  logic        m_done = 1'b0;
  logic [63:0] m_result = 64'h0;
  logic [63:0] m_pend = 64'h0;

  always @(posedge clk or posedge arst) begin
    if (arst) begin
      m_left   <= 0;
      m_done   <= 1'b0;
      m_result <= 64'h0;
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (m_left > 0) begin
      if (flush) begin
        m_left <= 0;
      end else begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_done   <= 1'b1;
          m_result <= m_pend;
        end
      end
    end else if (start && !flush) begin
      if (ref_special(func3, word, src_1, src_2)) begin
        m_done   <= 1'b1;
        m_result <= ref_result(func3, word, src_1, src_2);
      end else begin
        m_left <= 64;
        m_pend <= ref_result(func3, word, src_1, src_2);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chkint("cyc_stall", int'(stall),
             int'((m_left > 0) || (!m_done && start && !flush)));
      chkint("cyc_busy", int'(busy), int'((m_left > 0) || m_done));
      chkint("cyc_done", int'(done), int'(m_done));
      chk64("cyc_result", result, m_result);
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  // Called at posedge+1; returns at posedge+1 of the cycle after DONE.
  task automatic do_op(input string name, input logic [2:0] f, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] lit, input int lat);
    int n, stalls, seen;
    bit got;
    chk64({name, "_model"}, ref_result(f, w, a, b), lit);
    func3 = f; word = w; src_1 = a; src_2 = b; start = 1'b1;
    n = 0; stalls = 0; seen = -1; got = 1'b0;
    while (!got && n < 200) begin
      @(negedge clk);
      if (stall) stalls++;
      if (done) begin
        got  = 1'b1;
        seen = n;
        chk64({name, "_result"}, result, lit);
      end
      @(posedge clk); #1;
      start = 1'b0;
      // Forwarded operands change after capture and must not matter.
      src_1 = ~a; src_2 = a ^ b;
      n++;
    end
    chkint({name, "_latency"}, seen, lat);
    chkint({name, "_stalls"}, stalls, lat);
  endtask

  initial begin
    arst = 1'b1; start = 1'b0; func3 = 3'd0; word = 1'b0;
    src_1 = 64'h0; src_2 = 64'h0; flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chkint("rst_stall", int'(stall), 0);
    chkint("rst_busy", int'(busy), 0);
    chkint("rst_done", int'(done), 0);
    chk64("rst_result", result, 64'h0);
    arst = 1'b0;
    cmp_en = 1'b1;
    @(posedge clk); #1;

    do_op("mul",      3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB, 65);
    do_op("mulhu",    3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    do_op("mulh",     3'd1, 1'b0, '1, '1, 64'h0, 65);
    do_op("mulhsu",   3'd2, 1'b0, '1, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    do_op("div",      3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    do_op("rem",      3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd6, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    do_op("divuw",    3'd5, 1'b1, 64'h1_0000_0010, 64'd4, 64'h4, 65);
    do_op("divw",     3'd4, 1'b1, 64'h1234_5678_FFFF_FFF9, 64'hABCD_0000_0000_0002,
          64'hFFFF_FFFF_FFFF_FFFD, 65);
    do_op("divu_z",   3'd5, 1'b0, 64'h123, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    do_op("rem_z",    3'd6, 1'b0, 64'h123, 64'h0, 64'h123, 1);
    do_op("div_ovf",  3'd4, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 1);
    do_op("rem_ovf",  3'd6, 1'b0, 64'h8000_0000_0000_0000, '1, 64'h0, 1);
    do_op("remu",     3'd7, 1'b0, 64'd100, 64'd7, 64'd2, 65);

    // Flush during CALC cycle 10: no completion, previous result held.
    func3 = 3'd3; word = 1'b0; src_1 = '1; src_2 = '1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chkint("flush_stall", int'(stall), 0);
    chkint("flush_busy", int'(busy), 0);
    chkint("flush_done", int'(done), 0);
    chk64("flush_result", result, 64'd2);
    @(posedge clk); #1;
    do_op("after_flush", 3'd3, 1'b0, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 65);

    // Asynchronous reset mid-CALC.
    func3 = 3'd3; src_1 = '1; src_2 = '1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
    end
    #1;
    arst = 1'b1;
    #1;
    chkint("arst_stall", int'(stall), 0);
    chkint("arst_busy", int'(busy), 0);
    chkint("arst_done", int'(done), 0);
    chk64("arst_result", result, 64'h0);
    @(posedge clk); #1;
    arst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chkint("arst_no_done", int'(done), 0);
      @(posedge clk); #1;
    end

    // Back-to-back: the second start comes right at DONE+1.
    do_op("mulw_a", 3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    do_op("mulw_b", 3'd0, 1'b1, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 65);

    repeat (2) @(posedge clk);
    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/exec_mdu_sequencer.md
# exec_mdu_sequencer

Multi-cycle multiply/divide sequencer for the RV64 M extension, attached beside the single-cycle ALU in the execute stage. It captures operands on an M-type instruction, runs an iterative radix-2 shift-add multiply or restoring divide, and holds the execute stage stalled until the result is ready. It owns its control FSM, iteration counter and operand/accumulator registers. It raises a one-cycle done pulse when the result is valid.

## Interface
Parameters:
- DATA_WIDTH, 64, operand/result width; iteration count equals DATA_WIDTH.

Ports:
- i_clk  in  1  clock, rising edge.
- i_arst  in  1  asynchronous, active-high reset.
- i_start  in  1  valid M-type instruction present in execute this cycle.
- i_func3  in  3  0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu.
- i_word  in  1  RV64 W variant (mulw/divw/divuw/remw/remuw).
- i_src_1  in  DATA_WIDTH  forwarded rs1 value.
- i_src_2  in  DATA_WIDTH  forwarded rs2 value.
- i_flush  in  1  branch mispredict/exception kill of the execute instruction.
- o_stall  out  1  hold fetch/decode/execute pipeline registers.
- o_busy  out  1  FSM not IDLE.
- o_done  out  1  o_result valid this cycle.
- o_result  out  DATA_WIDTH  final result; held until the next capture.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE with i_start=1 and i_flush=0: capture operands, op and word flag.
  - Special case present: go to DONE.
  - Otherwise: go to CALC with counter = 0.
- CALC: one iteration per cycle. When counter = DATA_WIDTH-1, go to DONE. Counter is log2(DATA_WIDTH)+1 bits and never wraps mid-op.
- DONE: o_done=1, then IDLE unconditionally. i_start is ignored in DONE; the pipeline advances on this edge and the next instruction is seen in IDLE.
- i_flush=1 in any state: next state IDLE, no o_done, o_result unchanged. i_flush overrides i_start.
- Operand prep:
  - Word ops: low 32 bits only, sign-extended for signed ops and zero-extended for unsigned.
  - Signed operands (mul/mulh/div/rem rs1+rs2, mulhsu rs1 only) are converted to magnitudes. Result signs are recorded at capture.
- Multiply: 2·DATA_WIDTH accumulator. Each iteration: if multiplier LSB set, add multiplicand to upper half, then shift right by 1. mul/mulw take the low half; mulh* take the high half.
  - Final negate of the full 2·DATA_WIDTH product when the sign is negative.
- Divide: restoring. Each iteration shifts the remainder left and brings in the next dividend bit, then subtracts if remainder ≥ divisor and sets the quotient bit.
  - Quotient sign = sign(rs1) XOR sign(rs2). Remainder sign = sign(rs1).
- Special cases, resolved in 1 cycle via IDLE→DONE:
  - Divisor 0: quotient all ones, remainder = dividend.
  - Signed overflow (min-int / −1): quotient = dividend, remainder 0.
  - Width is 32-bit for W ops.
- Word results: bit 31 is sign-extended to DATA_WIDTH.
- Reset values: state IDLE, o_stall 0, o_busy 0, o_done 0, o_result 0, counter 0, all internal registers 0.

## Timing
- o_stall = (IDLE & i_start & ~i_flush) | CALC. It is combinational on i_start in IDLE, so the start cycle is stalled. It is low in DONE.
- Normal op: start at cycle t; CALC t+1…t+DATA_WIDTH; DONE at t+DATA_WIDTH+1. Total stall is DATA_WIDTH+1 cycles (65 at default).
- Special case: start at t; DONE at t+1; stall 1 cycle.
- o_done is exactly one cycle wide, registered. o_result is valid from the DONE cycle until the next capture.
- Back-to-back ops: the second start is accepted earliest at DONE+1.
- Asynchronous reset mid-CALC: immediately IDLE with all outputs at reset values; no o_done after release.

## Test plan
- mul 7 × −3 (0x…FFFD): o_stall high 65 cycles, o_done at t+65, o_result = 0xFFFFFFFFFFFFFFEB.
- mulhu 0xFFFFFFFFFFFFFFFF × 0xFFFFFFFFFFFFFFFF → 0xFFFFFFFFFFFFFFFE; mulh of the same operands → 0.
- div −20 / 6 → −3 (0xFFFFFFFFFFFFFFFD); rem → −2; divuw 0x1_00000010 / 4 → 0x4.
- divu x/0 → 0xFFFFFFFFFFFFFFFF and rem x/0 → x, with o_done at t+1. div 0x8000000000000000 / −1 → 0x8000000000000000, and rem of the same → 0, both in 1 cycle.
- i_flush at CALC cycle 10: FSM IDLE next cycle, o_stall drops, no o_done, o_result keeps the previous value. A new i_start the following cycle completes normally.
- i_arst asserted mid-CALC, then two back-to-back mulw 0x7FFFFFFF × 2 ops: outputs reset immediately. Each op gives o_result 0xFFFFFFFFFFFFFFFE, and the second start is accepted at DONE+1.
